key_action_decoder: RTL and testbench

KEY_ACTION_DECODER -- requirements
Module: key_action_decoder

---
 rtl/key_pkg.sv | 57 +++++
 rtl/key_repeat_unit.sv | 64 ++++++
 rtl/key_action_decoder.sv | 76 +++++++
 tb/tb_key_action_decoder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key action decoder: game states, action slots,
// scancodes and the fixed four-player key map.
package key_pkg;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'b00,
        GS_RUN   = 2'b01,
        GS_PAUSE = 2'b10
    } game_state_e;

    typedef enum logic [1:0] {
        ACT_ROTATE = 2'd0,
        ACT_LEFT   = 2'd1,
        ACT_DOWN   = 2'd2,
        ACT_RIGHT  = 2'd3
    } action_e;

    typedef enum logic [7:0] {
        SC_SPACE = 8'h29,
        SC_P     = 8'h4D,
        SC_ESC   = 8'h76,
        SC_M     = 8'h3A,
        SC_ENTER = 8'h5A
    } scancode_e;

    localparam int unsigned ACTS_PER_PLAYER = 4;
    localparam int unsigned MAP_SIZE        = 16;

    typedef struct packed {
        logic       valid;
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_id_t;

    // Index = player*4 + action, action order {rotate, left, down, right}.
    localparam key_id_t KEY_MAP [MAP_SIZE] = '{
        '{1'b0, 8'h1D}, '{1'b0, 8'h1C}, '{1'b0, 8'h1B}, '{1'b0, 8'h23},
        '{1'b1, 8'h75}, '{1'b1, 8'h6B}, '{1'b1, 8'h72}, '{1'b1, 8'h74},
        '{1'b0, 8'h43}, '{1'b0, 8'h3B}, '{1'b0, 8'h42}, '{1'b0, 8'h4B},
        '{1'b0, 8'h75}, '{1'b0, 8'h6B}, '{1'b0, 8'h73}, '{1'b0, 8'h74}
    };

    function automatic logic is_plain(input key_event_t ev, input scancode_e code);
        return ev.valid && !ev.ext && (ev.code == code);
    endfunction

    function automatic logic is_make(input key_event_t ev, input scancode_e code);
        return is_plain(ev, code) && !ev.brk;
    endfunction

endpackage

// File: rtl/key_repeat_unit.sv
// One action key: held flag, hold counter and the make / auto-repeat pulse.
module key_repeat_unit
    import key_pkg::*;
#(
    parameter int unsigned DAS_CYCLES = 16_000_000,
    parameter int unsigned ARR_CYCLES = 5_000_000,
    parameter bit          REPEAT_EN  = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic make,
    input  logic brk,
    input  logic run,
    output logic held,
    output logic pulse
);

    localparam int unsigned CNT_W = $clog2(DAS_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic             rep;
    logic             due_c;

    // The event cycle counts as held time, so the first repeat lands DAS
    // cycles after the key_event and later ones ARR cycles after each pulse.
    always_comb begin
        due_c = 1'b0;
        if (REPEAT_EN && held) begin
            if (rep) due_c = (32'(cnt) + 32'd1) >= ARR_CYCLES;
            else     due_c = (32'(cnt) + 32'd2) >= DAS_CYCLES;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            held  <= 1'b0;
            cnt   <= '0;
            rep   <= 1'b0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (brk) begin
                held <= 1'b0;
                cnt  <= '0;
                rep  <= 1'b0;
            end else if (make && !held) begin
                held  <= 1'b1;
                cnt   <= '0;
                rep   <= 1'b0;
                pulse <= run;
            end else if (held) begin
                // Outside RUN the counter saturates so repeats resume promptly.
                if (due_c && run) begin
                    pulse <= 1'b1;
                    cnt   <= '0;
                    rep   <= 1'b1;
                end else if (32'(cnt) < DAS_CYCLES) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/key_action_decoder.sv
// PS/2 key event decoder: per-player action pulses with auto-repeat, game
// state machine (IDLE/RUN/PAUSE) and music enable toggle.
module key_action_decoder
    import key_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned DAS_CYCLES  = 16_000_000,
    parameter int unsigned ARR_CYCLES  = 5_000_000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [10:0]              key_event,
    output logic [4*NUM_PLAYERS-1:0] act_pulse,
    output logic [4*NUM_PLAYERS-1:0] act_held,
    output logic [1:0]               game_state,
    output logic                     start_pulse,
    output logic                     music_en
);

    localparam int unsigned NUM_ACTS = ACTS_PER_PLAYER * NUM_PLAYERS;

    key_event_t  ev;
    key_id_t     ev_id;
    game_state_e state;
    logic        m_held;

    assign ev         = key_event_t'(key_event);
    assign ev_id      = '{ext: ev.ext, code: ev.code};
    assign game_state = state;

    for (genvar i = 0; i < NUM_ACTS; i++) begin : g_act
        logic hit_c;
        assign hit_c = ev.valid && (ev_id == KEY_MAP[i]);

        key_repeat_unit #(
            .DAS_CYCLES (DAS_CYCLES),
            .ARR_CYCLES (ARR_CYCLES),
            .REPEAT_EN  ((i % ACTS_PER_PLAYER) != 32'(ACT_ROTATE))
        ) u_unit (
            .clk   (clk),
            .rstn  (rstn),
            .make  (hit_c && !ev.brk),
            .brk   (hit_c && ev.brk),
            .run   (state == GS_RUN),
            .held  (act_held[i]),
            .pulse (act_pulse[i])
        );
    end

    // Game FSM reacts to every make; music toggles only on a fresh M press.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= GS_IDLE;
            start_pulse <= 1'b0;
            music_en    <= 1'b0;
            m_held      <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            if (is_make(ev, SC_ESC)) begin
                state <= GS_IDLE;
            end else if ((is_make(ev, SC_SPACE) && (state != GS_RUN)) ||
                         (is_make(ev, SC_P) && (state == GS_PAUSE))) begin
                state       <= GS_RUN;
                start_pulse <= 1'b1;
            end else if (is_make(ev, SC_P) && (state == GS_RUN)) begin
                state <= GS_PAUSE;
            end

            if (is_plain(ev, SC_M)) begin
                m_held <= !ev.brk;
                if (!ev.brk && !m_held) music_en <= !music_en;
            end
        end
    end

endmodule

// File: tb/tb_key_action_decoder.sv
// Randomized + directed bench for key_action_decoder with a timestamp-based
// reference model feeding a scoreboard queue checked by a separate monitor.
module tb_key_action_decoder;

    localparam int NP  = 2;
    localparam int DAS = 8;
    localparam int ARR = 4;
    localparam int NA  = 4 * NP;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [10:0]   key_event = '0;
    logic [NA-1:0] act_pulse;
    logic [NA-1:0] act_held;
    logic [1:0]    game_state;
    logic          start_pulse;
    logic          music_en;

    key_action_decoder #(
        .NUM_PLAYERS (NP),
        .DAS_CYCLES  (DAS),
        .ARR_CYCLES  (ARR)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .key_event   (key_event),
        .act_pulse   (act_pulse),
        .act_held    (act_held),
        .game_state  (game_state),
        .start_pulse (start_pulse),
        .music_en    (music_en)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NA-1:0] pulse;
        logic [NA-1:0] held;
        logic [1:0]    gs;
        logic          start;
        logic          music;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   obs_pulse[NA];
    int   obs_start = 0;

    // {ext, code} per player*4 + {rotate, left, down, right}
    logic [8:0] kmap [16] = '{
        9'h01D, 9'h01C, 9'h01B, 9'h023,
        9'h175, 9'h16B, 9'h172, 9'h174,
        9'h043, 9'h03B, 9'h042, 9'h04B,
        9'h075, 9'h06B, 9'h073, 9'h074
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: time-stamped holds, evaluated on each rising edge.
    bit  m_held[NA];
    int  m_ref[NA];
    int  m_thr[NA];
    int  m_gs = 0;
    bit  m_music = 1'b0;
    bit  m_mkey = 1'b0;
    int  n = 0;

    always @(posedge clk) begin
        exp_t       e;
        bit         v, ex, br, run, hit;
        logic [7:0] c;
        e = '0;
        if (!rstn) begin
            for (int i = 0; i < NA; i++) m_held[i] = 1'b0;
            m_gs = 0; m_music = 1'b0; m_mkey = 1'b0;
        end else begin
            v = key_event[10]; ex = key_event[9]; br = key_event[8]; c = key_event[7:0];
            run = (m_gs == 1);
            for (int i = 0; i < NA; i++) begin
                hit = v && ({ex, c} == kmap[i]);
                if (hit && br) begin
                    m_held[i] = 1'b0;
                end else if (hit && !m_held[i]) begin
                    m_held[i] = 1'b1; m_ref[i] = n; m_thr[i] = DAS; e.pulse[i] = run;
                end else if (m_held[i] && (i % 4) != 0 && run && (n + 1 - m_ref[i]) >= m_thr[i]) begin
                    e.pulse[i] = 1'b1; m_ref[i] = n + 1; m_thr[i] = ARR;
                end
            end
            if (v && !ex && !br) begin
                if (c == 8'h76) m_gs = 0;
                else if ((c == 8'h29 && m_gs != 1) || (c == 8'h4D && m_gs == 2)) begin
                    m_gs = 1; e.start = 1'b1;
                end else if (c == 8'h4D && m_gs == 1) m_gs = 2;
                if (c == 8'h3A && !m_mkey) m_music = !m_music;
            end
            if (v && !ex && c == 8'h3A) m_mkey = !br;
        end
        for (int i = 0; i < NA; i++) e.held[i] = m_held[i];
        e.gs = 2'(m_gs);
        e.music = m_music;
        q.push_back(e);
        n++;
    end

    // Monitor: pop one expectation per clock and compare against the DUT.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            chk("act_pulse", 32'(act_pulse), 32'(e.pulse));
            chk("act_held", 32'(act_held), 32'(e.held));
            chk("game_state", 32'(game_state), 32'(e.gs));
            chk("start_pulse", 32'(start_pulse), 32'(e.start));
            chk("music_en", 32'(music_en), 32'(e.music));
        end
        for (int i = 0; i < NA; i++) if (act_pulse[i]) obs_pulse[i]++;
        if (start_pulse) obs_start++;
    end

    task automatic clear_obs();
        for (int i = 0; i < NA; i++) obs_pulse[i] = 0;
        obs_start = 0;
    endtask

    function automatic int sum_obs();
        int s = 0;
        for (int i = 0; i < NA; i++) s += obs_pulse[i];
        return s;
    endfunction

    task automatic send(input bit ext, input bit brk, input logic [7:0] code);
        @(negedge clk); key_event = {1'b1, ext, brk, code};
        @(negedge clk); key_event = '0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    function automatic logic [10:0] rand_event();
        logic [8:0] k;
        int  r;
        bit  br;
        r  = $urandom_range(0, 15);
        br = ($urandom_range(0, 2) == 0);
        if (r <= 9) begin
            k = kmap[$urandom_range(0, 15)];
            if ($urandom_range(0, 7) == 0) k[8] = ~k[8];
        end else if (r == 10) k = 9'h029;
        else if (r == 11) k = 9'h04D;
        else if (r == 12) k = ($urandom_range(0, 3) == 0) ? 9'h076 : 9'h05A;
        else if (r == 13) k = 9'h03A;
        else if (r == 14) k = 9'h05A;
        else k = 9'($urandom);
        return {1'b1, k[8], br, k[7:0]};
    endfunction

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clear_obs();
        idle(3);
        chk("reset_game_state", 32'(game_state), 32'd0);
        chk("reset_held", 32'(act_held), 32'd0);
        rstn = 1'b1;
        idle(2);

        // Game FSM: space -> RUN, P -> PAUSE, P -> RUN
        clear_obs();
        send(0, 0, 8'h29);
        chk("space_start", 32'(start_pulse), 32'd1);
        chk("space_state", 32'(game_state), 32'd1);
        send(0, 1, 8'h29);
        send(0, 0, 8'h4D);
        chk("p_pause", 32'(game_state), 32'd2);
        send(0, 1, 8'h4D);
        send(0, 0, 8'h4D);
        chk("p_resume_state", 32'(game_state), 32'd1);
        chk("p_resume_start", 32'(start_pulse), 32'd1);
        send(0, 1, 8'h4D);
        chk("start_count", 32'(obs_start), 32'd2);

        // A held 20 cycles: left pulses at +1, +8, +12, +16, +20
        clear_obs();
        send(0, 0, 8'h1C);
        chk("a_held", 32'(act_held[1]), 32'd1);
        idle(18);
        send(0, 1, 8'h1C);
        idle(10);
        chk("left_pulse_count", 32'(obs_pulse[1]), 32'd5);
        chk("a_released", 32'(act_held[1]), 32'd0);

        // W typematic: one rotate pulse only
        clear_obs();
        send(0, 0, 8'h1D); idle(3);
        send(0, 0, 8'h1D); idle(3);
        send(0, 0, 8'h1D); idle(12);
        chk("rotate_count", 32'(obs_pulse[0]), 32'd1);
        chk("w_held", 32'(act_held[0]), 32'd1);
        send(0, 1, 8'h1D);

        // 75 non-ext belongs to absent P3; 75 ext is P1 rotate
        clear_obs();
        send(0, 0, 8'h75); idle(3);
        chk("p3_ignored_pulses", 32'(sum_obs()), 32'd0);
        chk("p3_ignored_held", 32'(act_held), 32'd0);
        send(0, 1, 8'h75);
        send(1, 0, 8'h75); idle(3);
        chk("p1_rotate", 32'(obs_pulse[4]), 32'd1);
        chk("p1_only", 32'(sum_obs()), 32'd1);
        send(1, 1, 8'h75);

        // D held during PAUSE, repeats resume on return to RUN
        send(0, 0, 8'h4D); send(0, 1, 8'h4D);
        clear_obs();
        send(0, 0, 8'h23);
        idle(20);
        chk("pause_d_held", 32'(act_held[3]), 32'd1);
        chk("pause_no_pulse", 32'(sum_obs()), 32'd0);
        send(0, 0, 8'h4D);
        idle(ARR);
        chk("resume_repeat", 32'(obs_pulse[3] != 0), 32'd1);
        send(0, 1, 8'h4D);
        send(0, 1, 8'h23);

        // Music toggle, typematic M, reset mid-hold
        send(0, 0, 8'h3A);
        chk("music_on", 32'(music_en), 32'd1);
        send(0, 0, 8'h3A);
        chk("music_typematic", 32'(music_en), 32'd1);
        send(0, 0, 8'h1C); idle(3);
        @(negedge clk); rstn = 1'b0;
        #1;
        chk("rst_music", 32'(music_en), 32'd0);
        chk("rst_held", 32'(act_held), 32'd0);
        chk("rst_pulse", 32'(act_pulse), 32'd0);
        chk("rst_state", 32'(game_state), 32'd0);
        chk("rst_start", 32'(start_pulse), 32'd0);
        @(negedge clk); rstn = 1'b1;
        idle(2);
        chk("post_rst_not_held", 32'(act_held[1]), 32'd0);
        send(0, 0, 8'h1C);
        chk("post_rst_remake", 32'(act_held[1]), 32'd1);
        send(0, 1, 8'h1C);
        send(0, 1, 8'h3A);

        // Randomized traffic against the model
        send(0, 0, 8'h29);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            rstn = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 3) == 0) key_event = rand_event();
            else key_event = {1'b0, 10'($urandom)};
        end
        @(negedge clk);
        rstn = 1'b1;
        key_event = '0;
        idle(4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
